// File: rtl/cla_pkg.sv
// Shared constants and the stage-1 record for the pipelined carry-lookahead adder.
package cla_pkg;
  localparam int CLA_W = 16;
  localparam int GRP_W = 4;
  localparam int N_GRP = CLA_W / GRP_W;

  typedef struct packed {
    logic [CLA_W-1:0] h;
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [N_GRP-1:0] G;
    logic [N_GRP-1:0] P;
    logic             cin;
    logic             sign;
    logic             a_msb;
    logic             b_msb;
  } s1_t;
endpackage

// File: rtl/cla_carry4.sv
// 4-bit lookahead cell: intra-group carries from a group carry-in, plus group G/P.
module cla_carry4 (
  input  logic [3:0] i_g,
  input  logic [3:0] i_p,
  input  logic       i_c_in,
  output logic [3:0] o_c,
  output logic       o_g_grp,
  output logic       o_p_grp
);
  assign o_c[0] = i_c_in;
  assign o_c[1] = i_g[0] | (i_p[0] & i_c_in);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c_in);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_c_in);

  assign o_g_grp = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                 | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
  assign o_p_grp = &i_p;
endmodule

// File: rtl/cla_gp4.sv
// Per-bit generate, propagate and half-sum terms for one 4-bit group.
module cla_gp4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_g,
  output logic [3:0] o_p,
  output logic [3:0] o_h
);
  assign o_g = i_a & i_b;
  assign o_p = i_a | i_b;
  assign o_h = i_a ^ i_b;
endmodule

// File: rtl/cla16_pipe.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready on both sides.
// Stage 1 registers g/p/h and group G/P; stage 2 resolves carries into the output register.
module cla16_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ofl
);
  logic [WIDTH-1:0] w_g, w_p, w_h;
  logic [N_GRP-1:0] w_grp_g, w_grp_p;
  logic [WIDTH-1:0] w_unused_c1;
  logic [N_GRP-1:0] w_unused_g2, w_unused_p2;
  logic [N_GRP:0]   w_grp_c;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout, w_ofl;
  logic             w_out_adv, w_accept;
  s1_t              w_s1_d;

  s1_t              r_s1;
  logic             r_s1_v;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ofl;

  assign w_out_adv = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_v || w_out_adv;
  assign w_accept  = in_valid && in_ready;

  for (genvar k = 0; k < N_GRP; k++) begin : g_grp
    cla_gp4 u_gp (
      .i_a (a[k*GRP_W +: GRP_W]),
      .i_b (b[k*GRP_W +: GRP_W]),
      .o_g (w_g[k*GRP_W +: GRP_W]),
      .o_p (w_p[k*GRP_W +: GRP_W]),
      .o_h (w_h[k*GRP_W +: GRP_W])
    );

    // Only G/P are wanted in stage 1; carries are resolved after the register.
    cla_carry4 u_s1 (
      .i_g     (w_g[k*GRP_W +: GRP_W]),
      .i_p     (w_p[k*GRP_W +: GRP_W]),
      .i_c_in  (1'b0),
      .o_c     (w_unused_c1[k*GRP_W +: GRP_W]),
      .o_g_grp (w_grp_g[k]),
      .o_p_grp (w_grp_p[k])
    );

    cla_carry4 u_s2 (
      .i_g     (r_s1.g[k*GRP_W +: GRP_W]),
      .i_p     (r_s1.p[k*GRP_W +: GRP_W]),
      .i_c_in  (w_grp_c[k]),
      .o_c     (w_c[k*GRP_W +: GRP_W]),
      .o_g_grp (w_unused_g2[k]),
      .o_p_grp (w_unused_p2[k])
    );
  end

  always_comb begin
    w_s1_d       = '0;
    w_s1_d.h     = w_h;
    w_s1_d.g     = w_g;
    w_s1_d.p     = w_p;
    w_s1_d.G     = w_grp_g;
    w_s1_d.P     = w_grp_p;
    w_s1_d.cin   = cin;
    w_s1_d.sign  = sign;
    w_s1_d.a_msb = a[WIDTH-1];
    w_s1_d.b_msb = b[WIDTH-1];
  end

  always_comb begin
    w_grp_c    = '0;
    w_grp_c[0] = r_s1.cin;
    for (int k = 0; k < N_GRP; k++) begin
      w_grp_c[k+1] = r_s1.G[k] | (r_s1.P[k] & w_grp_c[k]);
    end
  end

  assign w_sum  = r_s1.h ^ w_c;
  assign w_cout = w_grp_c[N_GRP];
  assign w_ofl  = r_s1.sign ? ((r_s1.a_msb == r_s1.b_msb) && (w_sum[WIDTH-1] != r_s1.a_msb))
                            : w_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1        <= '0;
      r_s1_v      <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ofl       <= 1'b0;
    end else begin
      if (w_out_adv) begin
        r_out_valid <= r_s1_v;
        if (r_s1_v) begin
          r_sum  <= w_sum;
          r_cout <= w_cout;
          r_ofl  <= w_ofl;
        end
      end
      // s1 refills whenever its content leaves or it is empty; a bubble clears s1_v.
      if (in_ready) begin
        r_s1_v <= in_valid;
        if (w_accept) r_s1 <= w_s1_d;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ofl       = r_ofl;
endmodule

// File: tb/tb_cla16_pipe.sv
// Bench for cla16_pipe: directed vector table, handshake corner sequences and a random
// phase checked against an arithmetic reference model through an in-order scoreboard.
module tb_cla16_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin, sign;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, ofl;
  logic [15:0] sum;

  int n_chk = 0, n_pass = 0, n_acc = 0, n_xfer = 0, cyc = 0;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        of;
  } res_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sign;
    logic [15:0] s;
    logic        co, of;
  } vec_t;

  res_t q[$];
  int   xfer_cyc[$];

  cla16_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ofl(ofl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sg);
    res_t r;
    int unsigned t;
    t    = int'(x) + int'(y) + int'(ci);
    r.s  = t[15:0];
    r.co = t[16];
    if (sg) r.of = (x[15] == y[15]) && (r.s[15] != x[15]);
    else    r.of = r.co;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: transfers are checked in order; hold of stalled output data is checked too.
  initial begin : monitor
    res_t        e;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_sum = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", {16'h0, sum}, {16'h0, prev_sum});
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
        if (out_valid && out_ready) begin
          chk("xfer_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("xfer_sum", {16'h0, sum}, {16'h0, e.s});
            chk("xfer_cout", {31'h0, cout}, {31'h0, e.co});
            chk("xfer_ofl", {31'h0, ofl}, {31'h0, e.of});
          end
          n_xfer++;
          xfer_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) begin
          q.push_back(model(a, b, cin, sign));
          n_acc++;
        end
      end
    end
  end

  task automatic drain();
    int budget = 50;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("drain_in_time", 32'(q.size()), 32'd0);
  endtask

  task automatic rand_ops();
    a    = 16'($urandom);
    b    = 16'($urandom);
    cin  = 1'($urandom_range(0, 1));
    sign = 1'($urandom_range(0, 1));
  endtask

  vec_t vt[9];

  initial begin
    int acc0, x0, last_acc;
    logic [15:0] held;

    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[3] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[4] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[5] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0};
    vt[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[8] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sign = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_sum", {16'h0, sum}, 32'd0);
    chk("rst_cout", {31'h0, cout}, 32'd0);
    chk("rst_ofl", {31'h0, ofl}, 32'd0);

    // Directed vectors, one at a time: result must be valid exactly one edge after accept.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sign = vt[i].sign;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("vec_not_early", {31'h0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("vec_valid", {31'h0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_sum", i), {16'h0, sum}, {16'h0, vt[i].s});
      chk($sformatf("vec%0d_cout", i), {31'h0, cout}, {31'h0, vt[i].co});
      chk($sformatf("vec%0d_ofl", i), {31'h0, ofl}, {31'h0, vt[i].of});
    end
    drain();

    // Back-to-back: 8 accepts on consecutive cycles, 8 transfers on consecutive cycles.
    @(posedge clk); #1;
    x0 = n_xfer;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      in_valid = 1'b1;
      chk("b2b_in_ready", {31'h0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_count", 32'(n_xfer - x0), 32'd8);
    if (xfer_cyc.size() >= 8)
      chk("b2b_consecutive", 32'(xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[xfer_cyc.size()-8]), 32'd7);

    // Backpressure: 4 stalled cycles with in_valid held.
    out_ready = 1'b0;
    rand_ops();
    in_valid = 1'b1;
    acc0 = n_acc;
    last_acc = n_acc;
    held = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (n_acc != last_acc) begin
        rand_ops();
        last_acc = n_acc;
      end
      if (c == 1) begin
        chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
        held = sum;
      end else if (c > 1) begin
        chk("bp_sum_held", {16'h0, sum}, {16'h0, held});
      end
    end
    chk("bp_accepts", 32'(n_acc - acc0), 32'd2);
    chk("bp_in_ready_low", {31'h0, in_ready}, 32'd0);
    in_valid = 1'b0;
    x0 = n_xfer;
    out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("bp_release_count", 32'(n_xfer - x0), 32'd2);

    // Reset mid-flight with both stages full and an accept offered in the same cycle.
    out_ready = 1'b0;
    a = 16'hF000; b = 16'hF000; cin = 1'b0; sign = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_full_in_ready", {31'h0, in_ready}, 32'd0);
    chk("mid_full_out_valid", {31'h0, out_valid}, 32'd1);
    chk("mid_full_sum", {16'h0, sum}, 32'h0000E000);
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'h0, sum}, 32'd0);
    chk("mid_rst_cout", {31'h0, cout}, 32'd0);
    chk("mid_rst_ofl", {31'h0, ofl}, 32'd0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("mid_rst_s1_flushed", {31'h0, out_valid}, 32'd0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      rand_ops();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("final_out_valid", {31'h0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
